// File: rtl/mem_arbiter_if.sv
// Bundle of the core-side fetch/data ports and the RAM-side port of the shared-memory arbiter.
// The arbiter uses the slave view; the core/RAM environment uses the master view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              f_req;
   logic [ADDR_W-1:0] f_addr;
   logic              f_gnt;
   logic              f_rvalid;
   logic [DATA_W-1:0] f_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   logic              m_en;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;

   modport slave (
      input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
             m_en, m_we, m_addr, m_wdata
   );

   modport master (
      output f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
             m_en, m_we, m_addr, m_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the fetch and load/store ports.
// Data port wins contention; fetch is forced through after MAX_WAIT consecutive denials.
module mem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic           clk,
   input  logic           rst,
   mem_arbiter_if.slave   bus
);
   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   // Down-counts fetch denials; reaching zero means the fetch has waited MAX_WAIT cycles.
   logic [CNT_W-1:0]  r_wait_left;
   logic              r_rsp_v;
   logic              r_rsp_id;

   logic              w_force;
   logic              w_f_gnt;
   logic              w_d_gnt;
   logic [ADDR_W-1:0] w_m_addr;
   logic [DATA_W-1:0] w_m_wdata;

   always_comb begin
      w_force   = bus.f_req && (r_wait_left == '0);
      w_f_gnt   = !rst && bus.f_req && (!bus.d_req || w_force);
      w_d_gnt   = !rst && bus.d_req && !w_f_gnt;
      w_m_addr  = '0;
      w_m_wdata = '0;
      if (w_f_gnt) begin
         w_m_addr = bus.f_addr;
      end else if (w_d_gnt) begin
         w_m_addr  = bus.d_addr;
         w_m_wdata = bus.d_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_left <= CNT_W'(MAX_WAIT);
         r_rsp_v     <= 1'b0;
         r_rsp_id    <= 1'b0;
      end else begin
         if (!bus.f_req || w_f_gnt) begin
            r_wait_left <= CNT_W'(MAX_WAIT);
         end else if (r_wait_left != '0) begin
            r_wait_left <= r_wait_left - CNT_W'(1);
         end
         r_rsp_v  <= w_f_gnt || (w_d_gnt && !bus.d_we);
         r_rsp_id <= w_f_gnt;
      end
   end

   assign bus.f_gnt    = w_f_gnt;
   assign bus.d_gnt    = w_d_gnt;
   assign bus.m_en     = w_f_gnt || w_d_gnt;
   assign bus.m_we     = w_d_gnt && bus.d_we;
   assign bus.m_addr   = w_m_addr;
   assign bus.m_wdata  = w_m_wdata;

   // Read data is shared; the rvalid tag says which port owns it.
   assign bus.f_rvalid = r_rsp_v && r_rsp_id;
   assign bus.d_rvalid = r_rsp_v && !r_rsp_id;
   assign bus.f_rdata  = bus.m_rdata;
   assign bus.d_rdata  = bus.m_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of priority, starvation bound and RAM contents.
module tb_mem_arbiter;
   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 4;
   localparam int CW       = 4 + ADDR_W + DATA_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   function automatic logic [DATA_W-1:0] init_word(input int a);
      if (a == 'h10) return 32'hDEADBEEF;
      return (a * 32'h9E3779B9) ^ 32'h5A5A_0000;
   endfunction

   // Environment RAM: one-cycle read latency, loaded on the first clock edge.
   logic [DATA_W-1:0] ram [256];
   logic              ram_loaded = 1'b0;
   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
         ram_loaded <= 1'b1;
      end else if (bus.m_en) begin
         if (bus.m_we) ram[bus.m_addr[7:0]] <= bus.m_wdata;
         else          bus.m_rdata <= ram[bus.m_addr[7:0]];
      end
   end

   // Reference model state
   logic [DATA_W-1:0] sm [256];
   int                denied;
   int                peak_denied;

   logic [CW-1:0]     obs_c, exp_c;
   logic [1:0]        obs_rv, exp_rv;
   logic [DATA_W-1:0] exp_rd;
   logic [2*DATA_W-1:0] obs_rd;
   logic              last_fg, last_dg;

   int n_checks = 0;
   int n_pass   = 0;

   // Drives one cycle, predicts its outcome and samples the DUT (no checking here).
   task automatic cycle(input logic r, input logic fr, input logic [ADDR_W-1:0] fa,
                        input logic dr, input logic dwe, input logic [ADDR_W-1:0] da,
                        input logic [DATA_W-1:0] dwd);
      logic ef, ed;
      logic [ADDR_W-1:0] ea;
      @(negedge clk);
      rst = r; bus.f_req = fr; bus.f_addr = fa;
      bus.d_req = dr; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd;
      if (r) begin
         ef = 1'b0; ed = 1'b0;
      end else begin
         ef = fr && (!dr || denied >= MAX_WAIT);
         ed = dr && !ef;
      end
      ea = ef ? fa : (ed ? da : '0);
      exp_c  = {ef, ed, ef | ed, ed & dwe, ea, (ed ? dwd : {DATA_W{1'b0}})};
      exp_rv = {ef, ed & !dwe};
      exp_rd = sm[ea[7:0]];
      if (ed && dwe) sm[da[7:0]] = dwd;
      if (r || !fr || ef) denied = 0;
      else if (denied < MAX_WAIT) denied++;
      if (denied > peak_denied) peak_denied = denied;
      #2;
      obs_c = {bus.f_gnt, bus.d_gnt, bus.m_en, bus.m_we, bus.m_addr, bus.m_wdata};
      last_fg = bus.f_gnt; last_dg = bus.d_gnt;
      @(posedge clk); #1;
      obs_rv = {bus.f_rvalid, bus.d_rvalid};
      obs_rd = {bus.f_rdata, bus.d_rdata};
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, 1'b1, 'h3, 1'b1, 1'b0, 'h4, '0);
         n_checks++;
         if (obs_c !== {CW{1'b0}}) $display("FAIL reset_drive got=%h want=0", obs_c);
         else n_pass++;
      end
      n_checks++;
      if (obs_rv !== 2'b00) $display("FAIL reset_rvalid got=%b want=00", obs_rv);
      else n_pass++;
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
      n_checks++;
      if (obs_c !== exp_c || obs_rv !== 2'b00)
         $display("FAIL reset_idle got=%h/%b want=%h/00", obs_c, obs_rv, exp_c);
      else n_pass++;
   endtask

   task automatic test_single_fetch();
      cycle(1'b0, 1'b1, 'h10, 1'b0, 1'b0, '0, '0);
      n_checks++;
      if (obs_c !== exp_c) $display("FAIL fetch_grant got=%h want=%h", obs_c, exp_c);
      else n_pass++;
      n_checks++;
      if (obs_rv !== 2'b10 || obs_rd[2*DATA_W-1:DATA_W] !== 32'hDEADBEEF)
         $display("FAIL fetch_rsp got=%b/%h want=10/deadbeef", obs_rv, obs_rd[2*DATA_W-1:DATA_W]);
      else n_pass++;
   endtask

   task automatic test_write_read();
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 'h20, 32'h1234);
      n_checks++;
      if (obs_c !== exp_c || obs_rv !== 2'b00)
         $display("FAIL data_write got=%h/%b want=%h/00", obs_c, obs_rv, exp_c);
      else n_pass++;
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 'h20, '0);
      n_checks++;
      if (obs_c !== exp_c) $display("FAIL data_read_grant got=%h want=%h", obs_c, exp_c);
      else n_pass++;
      n_checks++;
      if (obs_rv !== 2'b01 || obs_rd[DATA_W-1:0] !== 32'h1234)
         $display("FAIL data_read_rsp got=%b/%h want=01/1234", obs_rv, obs_rd[DATA_W-1:0]);
      else n_pass++;
   endtask

   task automatic test_contention();
      logic [ADDR_W-1:0] fa;
      peak_denied = 0;
      fa = ADDR_W'($urandom_range(0, 255));
      for (int i = 0; i < 15; i++) begin
         cycle(1'b0, 1'b1, fa, 1'b1, 1'b0, ADDR_W'($urandom_range(0, 255)), '0);
         n_checks++;
         if (obs_c !== exp_c || last_fg !== ((i % 5) == 4))
            $display("FAIL contention_grant cyc=%0d got=%h want=%h", i, obs_c, exp_c);
         else n_pass++;
         n_checks++;
         if (obs_rv !== exp_rv || obs_rd !== {exp_rd, exp_rd})
            $display("FAIL contention_rsp cyc=%0d got=%b/%h want=%b/%h", i, obs_rv, obs_rd, exp_rv, exp_rd);
         else n_pass++;
         if (last_fg) fa = ADDR_W'($urandom_range(0, 255));
      end
      n_checks++;
      if (peak_denied !== MAX_WAIT) $display("FAIL contention_peak got=%0d want=%0d", peak_denied, MAX_WAIT);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 'h5, '0);
      n_checks++;
      if (obs_c !== exp_c || obs_rv !== 2'b01 || obs_rd[DATA_W-1:0] !== sm[5])
         $display("FAIL b2b_data got=%b/%h want=01/%h", obs_rv, obs_rd[DATA_W-1:0], sm[5]);
      else n_pass++;
      cycle(1'b0, 1'b1, 'h6, 1'b0, 1'b0, '0, '0);
      n_checks++;
      if (obs_c !== exp_c || obs_rv !== 2'b10 || obs_rd[2*DATA_W-1:DATA_W] !== sm[6])
         $display("FAIL b2b_fetch got=%b/%h want=10/%h", obs_rv, obs_rd[2*DATA_W-1:DATA_W], sm[6]);
      else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 'h7, '0);
      n_checks++;
      if (obs_c !== exp_c || obs_rv !== 2'b01) $display("FAIL midrst_grant got=%h/%b want=%h/01", obs_c, obs_rv, exp_c);
      else n_pass++;
      cycle(1'b1, 1'b1, 'h9, 1'b1, 1'b0, 'h8, '0);
      n_checks++;
      if (obs_c !== {CW{1'b0}} || obs_rv !== 2'b00)
         $display("FAIL midrst_suppress got=%h/%b want=0/00", obs_c, obs_rv);
      else n_pass++;
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 'h7, '0);
      n_checks++;
      if (obs_c !== exp_c || obs_rv !== 2'b01 || obs_rd[DATA_W-1:0] !== sm[7])
         $display("FAIL midrst_recover got=%b/%h want=01/%h", obs_rv, obs_rd[DATA_W-1:0], sm[7]);
      else n_pass++;
   endtask

   task automatic test_random();
      logic fr, dr, dwe, r;
      logic [ADDR_W-1:0] fa, da;
      logic [DATA_W-1:0] dwd;
      fr = 0; dr = 0; dwe = 0; fa = '0; da = '0; dwd = '0;
      for (int i = 0; i < 300; i++) begin
         if (!fr && $urandom_range(0, 3) != 0) begin
            fr = 1'b1; fa = ADDR_W'($urandom_range(0, 255));
         end
         if (!dr && $urandom_range(0, 2) != 0) begin
            dr = 1'b1; dwe = 1'($urandom_range(0, 1));
            da = ADDR_W'($urandom_range(0, 255)); dwd = $urandom;
         end
         r = ($urandom_range(0, 59) == 0);
         cycle(r, fr, fa, dr, dwe, da, dwd);
         n_checks++;
         if (obs_c !== exp_c) $display("FAIL random_drive cyc=%0d got=%h want=%h", i, obs_c, exp_c);
         else n_pass++;
         n_checks++;
         if (obs_rv !== exp_rv || (exp_rv != 2'b00 && obs_rd !== {exp_rd, exp_rd}))
            $display("FAIL random_rsp cyc=%0d got=%b/%h want=%b/%h", i, obs_rv, obs_rd, exp_rv, exp_rd);
         else n_pass++;
         if (last_fg) fr = 1'b0;
         if (last_dg) dr = 1'b0;
      end
   endtask

   initial begin
      bus.f_req = 0; bus.f_addr = '0; bus.d_req = 0; bus.d_we = 0;
      bus.d_addr = '0; bus.d_wdata = '0;
      for (int i = 0; i < 256; i++) sm[i] = init_word(i);
      denied = 0; peak_denied = 0;
      test_reset();
      test_single_fetch();
      test_write_read();
      test_contention();
      test_back_to_back();
      test_reset_mid_read();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
